// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide sequencer.
// Provides the funct3 op encoding, FSM states, the captured-operand payload
// and predicates that classify an op by divide/multiply and operand signedness.
package muldiv_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned XLEN2        = 2 * XLEN;
    localparam int unsigned MULDIV_STEPS = 32;
    localparam int unsigned CNT_W        = 5;

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Operation captured on the accept edge
    typedef struct packed {
        op_e             op;
        logic            sign_a;
        logic            sign_b;
        logic            div0;
        logic [XLEN-1:0] mag_a;
        logic [XLEN-1:0] mag_b;
    } opnd_t;

    function automatic logic is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_signed_a(input op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign correction and result selection.
// Ports: op_i (funct3), raw_i (product, or {remainder, quotient} for divides),
//        sign_a_i/sign_b_i (effective operand signs), div0_i (divisor was zero),
//        result_c (final 32-bit result).
module muldiv_signfix
    import muldiv_pkg::*;
(
    input  op_e              op_i,
    input  logic [XLEN2-1:0] raw_i,
    input  logic             sign_a_i,
    input  logic             sign_b_i,
    input  logic             div0_i,
    output logic [XLEN-1:0]  result_c
);

    logic [XLEN2-1:0] prod;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  rem;
    logic             quo_neg;

    // Division by zero must yield all-ones regardless of the dividend sign
    assign quo_neg = (sign_a_i ^ sign_b_i) & ~div0_i;
    assign prod    = (sign_a_i ^ sign_b_i) ? (~raw_i + XLEN2'(1)) : raw_i;
    assign quo     = quo_neg  ? (~raw_i[XLEN-1:0] + XLEN'(1)) : raw_i[XLEN-1:0];
    assign rem     = sign_a_i ? (~raw_i[XLEN2-1:XLEN] + XLEN'(1)) : raw_i[XLEN2-1:XLEN];

    always_comb begin
        result_c = '0;
        case (op_i)
            OP_MUL:                        result_c = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result_c = prod[XLEN2-1:XLEN];
            OP_DIV, OP_DIVU:               result_c = quo;
            OP_REM, OP_REMU:               result_c = rem;
            default:                       result_c = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer (32-step shift-add / restoring).
// Ports: clk, rst_n (async active-low); start/op/A/B request sampled when
//        ready=1; flush aborts CALC/FIX; ready (IDLE), busy (CALC/FIX),
//        done (one-cycle pulse), Q (result, held until the next done).
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] Q
);

    state_e           state_q, state_d;
    opnd_t            opnd_q, opnd_d, opnd_in;
    logic [XLEN2-1:0] acc_q, acc_d, acc_step;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  q_q, q_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    op_e              op_in;
    logic             in_sign_a, in_sign_b, in_div0, in_ovf;
    logic             accept_c, special_c, last_step_c;

    logic             fix_sel;
    opnd_t            fix_opnd;
    logic [XLEN2-1:0] fix_raw;
    logic [XLEN-1:0]  fix_result_c;

    // Operand capture: effective signs, magnitudes and special-case detection
    assign op_in     = op_e'(op);
    assign in_sign_a = is_signed_a(op_in) & A[XLEN-1];
    assign in_sign_b = is_signed_b(op_in) & B[XLEN-1];
    assign in_div0   = is_div(op_in) && (B == '0);
    assign in_ovf    = is_div(op_in) && is_signed_a(op_in)
                       && (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);

    assign opnd_in.op     = op_in;
    assign opnd_in.sign_a = in_sign_a;
    assign opnd_in.sign_b = in_sign_b;
    assign opnd_in.div0   = in_div0;
    assign opnd_in.mag_a  = in_sign_a ? (~A + XLEN'(1)) : A;
    assign opnd_in.mag_b  = in_sign_b ? (~B + XLEN'(1)) : B;

    assign accept_c    = (state_q == ST_IDLE) && start && !flush;
    assign special_c   = FAST_SPECIAL && (in_div0 || in_ovf);
    assign last_step_c = (cnt_q == CNT_W'(MULDIV_STEPS - 1));

    // One shift-add or restoring-divide iteration on acc_q
    logic [XLEN:0]   mul_addend;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN+1:0] div_diff;

    always_comb begin
        mul_addend = acc_q[0] ? {1'b0, opnd_q.mag_a} : '0;
        mul_sum    = {1'b0, acc_q[XLEN2-1:XLEN]} + mul_addend;
        div_shift  = {acc_q[XLEN2-1:XLEN], acc_q[XLEN-1]};
        div_diff   = {1'b0, div_shift} - {2'b00, opnd_q.mag_b};
        if (is_div(opnd_q.op)) begin
            if (div_diff[XLEN+1]) begin
                acc_step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end else begin
                acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign fix shared by FIX (iterated result) and the fast special path (live inputs)
    assign fix_sel  = (state_q == ST_FIX);
    assign fix_opnd = fix_sel ? opnd_q : opnd_in;
    assign fix_raw  = fix_sel ? acc_q
                    : (in_div0 ? {opnd_in.mag_a, {XLEN{1'b1}}}
                               : {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}});

    muldiv_signfix u_signfix (
        .op_i     (fix_opnd.op),
        .raw_i    (fix_raw),
        .sign_a_i (fix_opnd.sign_a),
        .sign_b_i (fix_opnd.sign_b),
        .div0_i   (fix_opnd.div0),
        .result_c (fix_result_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = special_c ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (last_step_c) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX:  state_d = flush ? ST_IDLE : ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic, registered from the next state
    always_comb begin
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d == ST_CALC) || (state_d == ST_FIX);
        done_d  = (state_d == ST_DONE);
    end

    // Datapath next values
    always_comb begin
        opnd_d = opnd_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        q_d    = q_q;
        if (accept_c) begin
            opnd_d = opnd_in;
            acc_d  = is_div(op_in) ? {{XLEN{1'b0}}, opnd_in.mag_a}
                                   : {{XLEN{1'b0}}, opnd_in.mag_b};
            cnt_d  = '0;
            if (special_c) begin
                q_d = fix_result_c;
            end
        end else if ((state_q == ST_CALC) && !flush) begin
            acc_d = acc_step;
            cnt_d = cnt_q + CNT_W'(1);
        end else if ((state_q == ST_FIX) && !flush) begin
            q_d = fix_result_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign Q     = q_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table plus flush, reset and busy-start sequences.
module tb_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] Q;

    int n_chk;
    int n_err;
    int dones;
    int n_ops;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        int          lat;
    } vec_t;

    vec_t vecs [24];

    muldiv_seq #(.FAST_SPECIAL(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .flush (flush),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .Q     (Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) dones++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one op from a point just after a negedge; ends just after the negedge following done.
    task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_q, input int exp_lat,
                          input bit poke);
        int lat;
        int bad_rdy;
        int bad_busy;
        bit got;
        chk({nm, "_ready_pre"}, 32'(ready), 32'd1);
        n_ops++;
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = $urandom; B = $urandom; op = 3'($urandom);
        lat = 0; bad_rdy = 0; bad_busy = 0; got = 1'b0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if (ready !== 1'b0) bad_rdy++;
            if (busy !== !done) bad_busy++;
            if (done === 1'b1) got = 1'b1;
            if (poke && lat >= 5 && lat <= 8) begin
                start = 1'b1; op = 3'd0; A = 32'd1; B = 32'd1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_q"}, Q, exp_q);
        chk({nm, "_ready_low"}, 32'(bad_rdy), 32'd0);
        chk({nm, "_busy"}, 32'(bad_busy), 32'd0);
        @(negedge clk);
        chk({nm, "_done_pulse"}, {30'd0, done, ready}, 32'd1);
        chk({nm, "_q_hold"}, Q, exp_q);
    endtask

    initial begin
        logic [31:0] prev_q;
        n_chk = 0; n_err = 0; dones = 0; n_ops = 0;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; A = '0; B = '0;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34};
        vecs[4]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
        vecs[5]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
        vecs[6]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
        vecs[7]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
        vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{3'd4, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, 1};
        vecs[13] = '{3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1};
        vecs[14] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         34};
        vecs[15] = '{3'd7, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34};
        vecs[16] = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         34};
        vecs[17] = '{3'd3, 32'h1234_5678,  32'h10,        32'd1,         34};
        vecs[18] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         34};
        vecs[19] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
        vecs[20] = '{3'd2, 32'd2,          32'hFFFF_FFFF, 32'd1,         34};
        vecs[21] = '{3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         34};
        vecs[22] = '{3'd5, 32'hFFFF_FFFF,  32'd0,         32'hFFFF_FFFF, 1};
        vecs[23] = '{3'd7, 32'hFFFF_FFFF,  32'd0,         32'hFFFF_FFFF, 1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_q",     Q,          32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table, back-to-back; vector 2 also pokes start while busy
        for (int i = 0; i < 24; i++) begin
            run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].q, vecs[i].lat, (i == 2));
        end

        // Start together with flush in IDLE is ignored
        start = 1'b1; flush = 1'b1; op = 3'd0; A = 32'd1; B = 32'd1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("idle_flush_ready", 32'(ready), 32'd1);
        chk("idle_flush_busy",  32'(busy),  32'd0);

        // Flush at CALC step 10
        prev_q = vecs[23].q;
        op = 3'd0; A = 32'd3; B = 32'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(negedge clk);
        chk("flush_pre_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_ready", 32'(ready), 32'd1);
        chk("flush_busy",  32'(busy),  32'd0);
        chk("flush_done",  32'(done),  32'd0);
        chk("flush_q",     Q,          prev_q);
        run_op("after_flush", 3'd3, 32'hFFFF_0000, 32'h0001_0000, 32'h0000_FFFF, 34, 1'b0);

        // Asynchronous reset mid-CALC
        op = 3'd5; A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(ready), 32'd1);
        chk("arst_busy",  32'(busy),  32'd0);
        chk("arst_done",  32'(done),  32'd0);
        chk("arst_q",     Q,          32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_idle", 32'(ready), 32'd1);
        run_op("after_rst", 3'd7, 32'd100, 32'd7, 32'd2, 34, 1'b0);

        repeat (3) @(negedge clk);
        chk("done_count", 32'(dones), 32'(n_ops));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
